// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_LT    = 4;
  localparam int NFLAGS    = 5;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module mul_iter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  // product exposes the value after the current step, so the last step's
  // result can be captured on the same edge that retires it
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == LAST);
  assign product  = prod_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; single-cycle ops plus an iterative MUL.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [4:0]       flags
);

  state_t state, state_n;
  alu_op_t op;
  logic accept, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   b_eff, res_c, mul_res;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shl_w;
  logic [SHW-1:0]     shamt;
  logic               sub, ovf_s, lt_s, c_c, v_c, l_c;
  logic [NFLAGS-1:0]  flg_c, flg_m;
  logic [WIDTH-1:0]   res_q;
  logic [NFLAGS-1:0]  flg_q;

  assign op        = alu_op_t'(ctrl);
  assign in_ready  = (state == S_IDLE) && !mul_busy && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign alu_result = res_q;
  assign flags      = flg_q;

  mul_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && (op == OP_MUL)),
    .a       (input_a),
    .b       (input_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // One shared adder: SUB and SLT both evaluate A + ~B + 1
  always_comb begin
    sub   = (op == OP_SUB) || (op == OP_SLT);
    b_eff = sub ? ~input_b : input_b;
    sum   = {1'b0, input_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    ovf_s = (input_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != input_a[WIDTH-1]);
    lt_s  = sum[WIDTH-1] ^ ovf_s;
    shamt = input_b[SHW-1:0];
    shl_w = {{WIDTH{1'b0}}, input_a} << shamt;

    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    l_c   = 1'b0;
    case (op)
      OP_ADD: begin res_c = sum[WIDTH-1:0]; c_c = sum[WIDTH]; v_c = ovf_s; end
      OP_SUB: begin res_c = sum[WIDTH-1:0]; c_c = sum[WIDTH]; v_c = ovf_s; l_c = lt_s; end
      OP_AND: res_c = input_a & input_b;
      OP_OR:  res_c = input_a | input_b;
      OP_XOR: res_c = input_a ^ input_b;
      OP_SLT: begin res_c = {{(WIDTH-1){1'b0}}, lt_s}; c_c = sum[WIDTH]; v_c = ovf_s; l_c = lt_s; end
      // bit WIDTH of the widened shift is the last bit pushed out of the top
      OP_SHL: begin res_c = shl_w[WIDTH-1:0]; c_c = (shamt != '0) && shl_w[WIDTH]; end
      default: ;
    endcase

    flg_c = '0;
    flg_c[FLG_ZERO]  = (res_c == '0);
    flg_c[FLG_NEG]   = res_c[WIDTH-1];
    flg_c[FLG_CARRY] = c_c;
    flg_c[FLG_OVF]   = v_c;
    flg_c[FLG_LT]    = l_c;

    mul_res = mul_prod[WIDTH-1:0];
    flg_m = '0;
    flg_m[FLG_ZERO]  = (mul_res == '0);
    flg_m[FLG_NEG]   = mul_res[WIDTH-1];
    flg_m[FLG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = (op == OP_MUL) ? S_BUSY : S_DONE;
      S_BUSY: if (mul_done) state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (accept && (op != OP_MUL)) begin
      res_q <= res_c;
      flg_q <= flg_c;
    end else if ((state == S_BUSY) && mul_done) begin
      res_q <= mul_res;
      flg_q <= flg_m;
    end
  end

endmodule
